// File: rtl/debug_pkg.sv
// Shared types and constants for the debug snapshot transmitter.
// Latency: n/a (package only).
// Backpressure: n/a.
//
// Contents: FSM state enum, frame header byte, snapshot geometry, byte-index width.
package debug_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    CSUM,
    DONE
  } dbg_state_e;

  localparam logic [7:0] DBG_HEADER = 8'hA5;
  localparam int         DBG_NWORDS = 9;
  localparam int         DBG_NBYTES = 36;
  localparam int         DBG_IDX_W  = 6;

endpackage

// File: rtl/snapshot_buffer.sv
// Capture registers for one pipeline snapshot plus a byte selector for read-out.
// Latency: capture on the edge where capture_i=1; byte_o is combinational from idx_i.
// Backpressure: none; the caller holds idx_i steady while a byte is stalled.
//
// Ports:
//   clk, reset  : clock, synchronous active-low reset (clears the buffer)
//   capture_i   : load snap_i into the buffer
//   snap_i      : concatenated taps, word 0 in the most significant position
//   idx_i       : byte index, 0 = MSB of word 0
//   byte_o      : selected byte
module snapshot_buffer
  import debug_pkg::*;
#(
  parameter int B = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     capture_i,
  input  logic [DBG_NWORDS*B-1:0]  snap_i,
  input  logic [DBG_IDX_W-1:0]     idx_i,
  output logic [7:0]               byte_o
);

  localparam int NBYTES = DBG_NWORDS * B / 8;

  // Viewing the flat snapshot as bytes puts the first transmitted byte at the
  // top index, so the selector just counts down from NBYTES-1.
  logic [NBYTES-1:0][7:0] buf_q;
  logic [DBG_IDX_W-1:0]   sel;

  always_ff @(posedge clk) begin
    if (!reset) begin
      buf_q <= '0;
    end else if (capture_i) begin
      buf_q <= snap_i;
    end
  end

  assign sel    = DBG_IDX_W'(NBYTES - 1) - idx_i;
  assign byte_o = buf_q[sel];

endmodule

// File: rtl/debug_snapshot_tx.sv
// Captures a pipeline snapshot on request and streams it as HEADER + data bytes (+ XOR checksum).
// Latency: header presented from the edge that samples snap_req; one byte per accepted handshake.
// Backpressure: tx_ready low holds state and tx_data; pipe_hold stalls the pipeline while busy.
//
// Ports:
//   clk, reset              : clock, synchronous active-low reset (aborts any frame)
//   snap_req                : snapshot request, sampled only in IDLE
//   pc_if..reg_20           : pipeline and register-file taps (B bits each)
//   tx_data/tx_valid/tx_ready : byte stream towards the UART transmitter
//   busy, pipe_hold         : frame in progress (identical)
//   frame_done              : one-cycle pulse after the last byte is accepted
// Build option: define DBG_CHECKSUM_EN to append the XOR checksum byte to each frame.
module debug_snapshot_tx
  import debug_pkg::*;
#(
  parameter int         B      = 32,
  parameter logic [7:0] HEADER = DBG_HEADER
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         snap_req,
  input  logic [B-1:0] pc_if,
  input  logic [B-1:0] instr_if,
  input  logic [B-1:0] alu_ex,
  input  logic [B-1:0] wb_data,
  input  logic [B-1:0] reg_16,
  input  logic [B-1:0] reg_17,
  input  logic [B-1:0] reg_18,
  input  logic [B-1:0] reg_19,
  input  logic [B-1:0] reg_20,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         busy,
  output logic         pipe_hold,
  output logic         frame_done
);

  dbg_state_e           state_q, state_d;
  logic [DBG_IDX_W-1:0] idx_q, idx_d;
  logic                 capture;
  logic                 accept;
  logic                 last_byte;
  logic [7:0]           data_byte;
`ifdef DBG_CHECKSUM_EN
  logic [7:0]           csum_q, csum_d;
`endif

  snapshot_buffer #(.B(B)) u_buf (
    .clk       (clk),
    .reset     (reset),
    .capture_i (capture),
    .snap_i    ({pc_if, instr_if, alu_ex, wb_data, reg_16, reg_17, reg_18, reg_19, reg_20}),
    .idx_i     (idx_q),
    .byte_o    (data_byte)
  );

  assign accept    = tx_valid && tx_ready;
  assign last_byte = (idx_q == DBG_IDX_W'(DBG_NBYTES - 1));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
`ifdef DBG_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
`ifdef DBG_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    capture = 1'b0;
`ifdef DBG_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      IDLE: begin
        if (snap_req) begin
          state_d = HDR;
          capture = 1'b1;
          idx_d   = '0;
`ifdef DBG_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      HDR: begin
        if (accept) state_d = DATA;
      end
      DATA: begin
        if (accept) begin
`ifdef DBG_CHECKSUM_EN
          csum_d = csum_q ^ data_byte;
`endif
          if (last_byte) begin
            idx_d = '0;
`ifdef DBG_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d = DONE;
`endif
          end else begin
            idx_d = idx_q + DBG_IDX_W'(1);
          end
        end
      end
`ifdef DBG_CHECKSUM_EN
      CSUM: begin
        if (accept) state_d = DONE;
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs depend on registered state only, so tx_ready never reaches tx_valid.
  always_comb begin
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    case (state_q)
      HDR: begin
        tx_valid = 1'b1;
        tx_data  = HEADER;
      end
      DATA: begin
        tx_valid = 1'b1;
        tx_data  = data_byte;
      end
`ifdef DBG_CHECKSUM_EN
      CSUM: begin
        tx_valid = 1'b1;
        tx_data  = csum_q;
      end
`endif
      default: begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
      end
    endcase
  end

  assign busy       = (state_q != IDLE);
  assign pipe_hold  = busy;
  assign frame_done = (state_q == DONE);

endmodule

// File: tb/tb_debug_snapshot_tx.sv
module tb_debug_snapshot_tx;

  logic        clk = 1'b0;
  logic        reset;
  logic        snap_req;
  logic        tx_ready;
  logic [31:0] taps [9];
  logic [7:0]  tx_data;
  logic        tx_valid, busy, pipe_hold, frame_done;

  int checks     = 0;
  int errors     = 0;
  int cyc        = 0;
  int done_count = 0;
  int done_cyc   = 0;
  int start_cyc  = 0;

  logic [7:0] exp_q [$];
  bit         last_q [$];
  bit         done_due = 1'b0;

`ifdef DBG_CHECKSUM_EN
  localparam int FLEN = 38;
`else
  localparam int FLEN = 37;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  debug_snapshot_tx #(.B(32), .HEADER(8'hA5)) dut (
    .clk        (clk),
    .reset      (reset),
    .snap_req   (snap_req),
    .pc_if      (taps[0]),
    .instr_if   (taps[1]),
    .alu_ex     (taps[2]),
    .wb_data    (taps[3]),
    .reg_16     (taps[4]),
    .reg_17     (taps[5]),
    .reg_18     (taps[6]),
    .reg_19     (taps[7]),
    .reg_20     (taps[8]),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .busy       (busy),
    .pipe_hold  (pipe_hold),
    .frame_done (frame_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expected byte per handshake; frame_done must follow the
  // last byte of a frame by exactly one cycle and appear at no other time.
  always @(negedge clk) begin
    logic [7:0] eb;
    bit         el;
    if (frame_done || done_due) chk("frame_done", frame_done, done_due);
    if (frame_done) begin
      done_count++;
      done_cyc = cyc;
    end
    done_due = 1'b0;
    if (reset && tx_valid && tx_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL extra_byte: got %0h expected no byte", tx_data);
      end else begin
        eb = exp_q.pop_front();
        el = last_q.pop_front();
        chk("tx_data", tx_data, eb);
        done_due = el;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_b(input logic [7:0] b, input bit l);
    exp_q.push_back(b);
    last_q.push_back(l);
  endtask

  // Hand-computed frame for pc_if=4, instr_if=8C100000, rest 0.
  task automatic push_frame1();
    logic [7:0] head [9];
    bit l;
    head = '{8'hA5, 8'h00, 8'h00, 8'h00, 8'h04, 8'h8C, 8'h10, 8'h00, 8'h00};
    for (int i = 0; i < 9; i++) push_b(head[i], 1'b0);
    for (int i = 0; i < 28; i++) begin
`ifdef DBG_CHECKSUM_EN
      l = 1'b0;
`else
      l = (i == 27);
`endif
      push_b(8'h00, l);
    end
`ifdef DBG_CHECKSUM_EN
    push_b(8'h98, 1'b1);
`endif
  endtask

  task automatic push_frame(input logic [31:0] w [9]);
    logic [7:0] cs;
    logic [7:0] b;
    bit l;
    cs = 8'h00;
    push_b(8'hA5, 1'b0);
    for (int i = 0; i < 9; i++) begin
      for (int k = 3; k >= 0; k--) begin
        b = w[i][8*k +: 8];
        cs ^= b;
`ifdef DBG_CHECKSUM_EN
        l = 1'b0;
`else
        l = (i == 8 && k == 0);
`endif
        push_b(b, l);
      end
    end
`ifdef DBG_CHECKSUM_EN
    push_b(cs, 1'b1);
`endif
  endtask

  task automatic set_taps(input logic [31:0] w [9]);
    for (int i = 0; i < 9; i++) taps[i] = w[i];
  endtask

  task automatic start();
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic run_frame(input string name, input int exp_len, input int d0);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 300);
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got busy after %0d cycles expected idle", name, n);
    end
    tick();
    chk({name, "_done_cnt"}, done_count - d0, 1);
    chk({name, "_len"}, done_cyc - start_cyc, exp_len);
    chk({name, "_leftover"}, exp_q.size(), 0);
  endtask

  initial begin
    logic [31:0] w1 [9];
    logic [31:0] wa [9];
    logic [31:0] wb [9];
    logic [31:0] wc [9];
    int d0;
    int n;

    w1 = '{32'h00000004, 32'h8C100000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    wa = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00, 32'h01020304,
           32'h05060708, 32'h090A0B0C, 32'h0D0E0F10, 32'hF0E1D2C3};
    wb = '{32'hFFFFFFFF, 32'hDEADBEEF, 32'hCAFEBABE, 32'h12345678, 32'h87654321,
           32'hA5A5A5A5, 32'h5A5A5A5A, 32'h0F0F0F0F, 32'hF0F0F0F0};
    wc = '{32'h00400020, 32'h2402FFFF, 32'h00000001, 32'h7FFFFFFF, 32'h80000000,
           32'h00000010, 32'h00000011, 32'h00000012, 32'h00000013};

    // Reset held with a pending request: nothing may start.
    reset    = 1'b0;
    snap_req = 1'b1;
    tx_ready = 1'b1;
    for (int i = 0; i < 9; i++) taps[i] = 32'h0;
    tick();
    repeat (3) begin
      @(negedge clk);
      chk("rst_valid", tx_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", frame_done, 0);
      chk("rst_data", tx_data, 0);
      tick();
    end
    reset    = 1'b1;
    snap_req = 1'b0;
    tick();
    chk("idle_busy", busy, 0);

    // Full frame with tx_ready held high.
    set_taps(w1);
    push_frame1();
    d0 = done_count;
    start();
    chk("hdr_valid", tx_valid, 1);
    chk("hdr_data", tx_data, 8'hA5);
    chk("hdr_busy", busy, 1);
    chk("hdr_hold", pipe_hold, 1);
    run_frame("full", FLEN, d0);

    // Backpressure while data byte 4 (8C) is presented.
    push_frame1();
    d0 = done_count;
    start();
    repeat (5) @(posedge clk);
    #1;
    tx_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("bp_data", tx_data, 8'h8C);
      chk("bp_valid", tx_valid, 1);
      tick();
    end
    tx_ready = 1'b1;
    run_frame("bp", FLEN + 3, d0);

    // Requests in DATA and DONE are ignored; taps changed mid-frame.
    set_taps(wa);
    push_frame(wa);
    d0 = done_count;
    start();
    repeat (6) tick();
    snap_req = 1'b1;
    set_taps(wb);
    tick();
    snap_req = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_done && n < 300);
    if (!frame_done) begin
      checks++;
      errors++;
      $display("FAIL ign_timeout: got no frame_done after %0d cycles", n);
    end
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("ign_busy", busy, 0);
      chk("ign_valid", tx_valid, 0);
      tick();
    end
    chk("ign_done_cnt", done_count - d0, 1);
    chk("ign_len", done_cyc - start_cyc, FLEN);
    chk("ign_leftover", exp_q.size(), 0);

    // Reset mid-frame at data byte 10, then a fresh frame.
    set_taps(wc);
    push_frame(wc);
    d0 = done_count;
    start();
    repeat (11) @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    chk("rm_valid", tx_valid, 0);
    chk("rm_busy", busy, 0);
    chk("rm_data", tx_data, 0);
    exp_q.delete();
    last_q.delete();
    reset = 1'b1;
    tick();
    tick();
    chk("rm_nodone", done_count - d0, 0);
    set_taps(w1);
    push_frame1();
    d0 = done_count;
    start();
    chk("rm_restart_hdr", tx_data, 8'hA5);
    run_frame("restart", FLEN, d0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/debug_snapshot_tx.md
# debug_snapshot_tx

Debug read-out side of the 5-stage MIPS pipeline. On request it captures one consistent snapshot of the pipeline's test taps, meaning the fetch PC, the fetched instruction, the EX ALU result, the WB write data and registers 16–20. It then streams the snapshot as a framed byte sequence over a valid/ready byte interface to the UART transmitter. It sits between the pipeline top and the UART TX, and holds the pipeline while a frame is in flight.

## Interface
- `B`, default 32: data word width. Must be a multiple of 8.
- `HEADER`, default 8'hA5: frame start byte.
- `clk`, in, 1: system clock.
- `reset`, in, 1: synchronous, active-low reset. Sampled on the rising edge of `clk`.
- `snap_req`, in, 1: snapshot request. Sampled only in IDLE.
- `pc_if`, `instr_if`, `alu_ex`, `wb_data`, in, B each: pipeline taps.
- `reg_16` … `reg_20`, in, B each: register file taps.
- `tx_data`, out, 8: byte to transmit.
- `tx_valid`, out, 1: `tx_data` is valid.
- `tx_ready`, in, 1: UART TX accepts the byte.
- `busy`, out, 1: a frame is in progress.
- `pipe_hold`, out, 1: stall request to the pipeline. Equal to `busy`.
- `frame_done`, out, 1: one-cycle pulse after the last byte is accepted.

## Operation
- Snapshot order is word 0..8: `pc_if`, `instr_if`, `alu_ex`, `wb_data`, `reg_16`, `reg_17`, `reg_18`, `reg_19`, `reg_20`. NWORDS is 9.
- Bytes are sent MSB first within each word, giving NBYTES = NWORDS·B/8 = 36 data bytes.
- Frame = `HEADER`, then 36 data bytes, then an optional checksum byte (see Configuration).
- States:
  - IDLE: waits for `snap_req`.
  - HDR: presents the header byte.
  - DATA: presents the data bytes in order.
  - CSUM: presents the checksum byte.
  - DONE: one cycle, then back to IDLE.
- IDLE → HDR on an edge with `snap_req`=1. On that same edge all 9 taps are latched into an internal buffer and the byte index and checksum are cleared.
- HDR → DATA on header acceptance.
- DATA advances the byte index (6 bits, 0..35) on each acceptance.
- On acceptance of byte 35, DATA → CSUM (macro defined) or DONE (macro undefined).
- CSUM → DONE on acceptance.
- Acceptance means `tx_valid` and `tx_ready` are both high on a rising edge.
- `tx_valid` is 1 in HDR, DATA and CSUM, and 0 in IDLE and DONE.
- While `tx_valid`=1 and `tx_ready`=0, `tx_data` and the state are held stable.
- The checksum is the XOR of the 36 data bytes. The header is excluded. It accumulates on each DATA acceptance.
- `snap_req` outside IDLE, including in DONE, is ignored and not queued.
- Taps that change after capture do not affect the frame in flight.

## Timing
- Reset values: `tx_data`=0, `tx_valid`=0, `busy`=0, `pipe_hold`=0, `frame_done`=0. State is IDLE, index and checksum are 0, the buffer is cleared.
- Reset low mid-frame aborts the frame. Outputs take their reset values on that edge, and no `frame_done` is produced.
- `snap_req` seen at edge N: `tx_valid`=1 with `tx_data`=`HEADER` and `busy`=1 from edge N onward.
- With `tx_ready` held at 1:
  - one byte is accepted per cycle;
  - the frame occupies 38 cycles in HDR, DATA and CSUM, or 37 without the checksum;
  - `frame_done`=1 for exactly the cycle after the last acceptance;
  - `busy` drops at the following edge.
- `busy` is high in every state except IDLE, including DONE.
- All outputs are registered or decoded from state only. There is no combinational path from `tx_ready` to `tx_valid`.

## Configuration
- Macro `DBG_CHECKSUM_EN`.
- Defined: the CSUM state exists, and the frame is 38 bytes ending with the XOR checksum.
- Undefined: there is no CSUM state and no checksum register. The frame is 37 bytes, and DATA goes directly to DONE.

## Structure
- Shared package `debug_pkg` holds:
  - the state enum (IDLE, HDR, DATA, CSUM, DONE);
  - `DBG_HEADER` (8'hA5);
  - `DBG_NWORDS` (9);
  - `DBG_NBYTES` (36);
  - the byte-index width (6).
- One sub-module, `snapshot_buffer`. It holds the 9×B capture registers, loaded on `capture`, and a combinational byte selector driven by the byte index.
- The FSM, index counter and checksum stay in the top block.

## Test plan
- **Reset:** hold `reset`=0 for 3 cycles with `snap_req`=1 → `tx_valid`=0, `busy`=0, `frame_done`=0 throughout.
- **Full frame:**
  - Stimulus: `tx_ready`=1; `pc_if`=32'h00000004, `instr_if`=32'h8C100000, all other taps 0; pulse `snap_req`.
  - Required bytes: A5, 00, 00, 00, 04, 8C, 10, 00, 00, followed by 28 bytes of 00, then checksum 0x98.
  - Required completion: `frame_done` pulses once, 1 cycle after the checksum is accepted.
- **Backpressure:** drop `tx_ready` for 3 cycles while data byte 4 is presented → `tx_data` stays 8'h8C, no byte is skipped or duplicated, and the frame is 3 cycles longer.
- **Ignored request:**
  - Stimulus: pulse `snap_req` in DATA and in DONE, and change all taps mid-frame.
  - Required response: exactly one frame, carrying the originally captured values, then IDLE with `busy`=0.
- **Reset mid-frame:** drop `reset` at data byte 10 → next cycle `tx_valid`=0. A new `snap_req` then yields a fresh frame starting with A5.
- **Macro off:** same stimulus as the full-frame test without `DBG_CHECKSUM_EN` → 37 bytes, and `frame_done` comes 1 cycle after the last 00 data byte.
